// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Arbitrates the common data bus (CDB) between three completion sources:
// EX (ALU/branch results), LD (load data) and ST (store address/data done).
// Each source owns a one-entry holding slot behind a valid/ready handshake.
// Occupied slots are granted round-robin (EX -> LD -> ST), and one registered
// broadcast leaves the block per enabled cycle. A branch clear empties every
// slot and cancels the broadcast.
//
// Ports:
//   clk_in, rst_in             clock, synchronous active-high reset
//   rdy_in                     global enable; low freezes every register
//   clear_branch_in            mispredict flush
//   ex_*                       EX request: valid/ready, rob_pos, res, jump_en, jump_a
//   ld_*                       LD request: valid/ready, rob_pos, res
//   st_*                       ST request: valid/ready, rob_pos
//   cdb_*_out                  registered broadcast: valid, kind, rob_pos, res,
//                              jump_en, jump_a
//   conflict_cnt_out           saturating count of cycles with >= 2 slots occupied
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int WORD_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int ROB_IDX_W = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear_branch_in,
    input  logic                 ex_valid_in,
    output logic                 ex_ready_out,
    input  logic [ROB_IDX_W-1:0] ex_rob_pos_in,
    input  logic [WORD_W-1:0]    ex_res_in,
    input  logic                 ex_jump_en_in,
    input  logic [ADDR_W-1:0]    ex_jump_a_in,
    input  logic                 ld_valid_in,
    output logic                 ld_ready_out,
    input  logic [ROB_IDX_W-1:0] ld_rob_pos_in,
    input  logic [WORD_W-1:0]    ld_res_in,
    input  logic                 st_valid_in,
    output logic                 st_ready_out,
    input  logic [ROB_IDX_W-1:0] st_rob_pos_in,
    output logic                 cdb_valid_out,
    output logic [1:0]           cdb_kind_out,
    output logic [ROB_IDX_W-1:0] cdb_rob_pos_out,
    output logic [WORD_W-1:0]    cdb_res_out,
    output logic                 cdb_jump_en_out,
    output logic [ADDR_W-1:0]    cdb_jump_a_out,
    output logic [CNT_W-1:0]     conflict_cnt_out
);

    localparam logic [1:0] KIND_EX = 2'd0;
    localparam logic [1:0] KIND_LD = 2'd1;
    localparam logic [1:0] KIND_ST = 2'd2;

    // Round-robin successor in the EX -> LD -> ST ring.
    function automatic logic [1:0] next_ptr(input logic [1:0] kind);
        return (kind == KIND_ST) ? KIND_EX : kind + 2'd1;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    endfunction

    // Holding slots (stage p0): occupancy plus payload
    logic                 occ_ex_p0, occ_ld_p0, occ_st_p0;
    logic [ROB_IDX_W-1:0] ex_pos_p0, ld_pos_p0, st_pos_p0;
    logic [WORD_W-1:0]    ex_res_p0, ld_res_p0;
    logic                 ex_jen_p0;
    logic [ADDR_W-1:0]    ex_ja_p0;

    logic [1:0]           rr_ptr;
    logic [CNT_W-1:0]     conflict_cnt;

    // Broadcast register (stage p1)
    logic                 cdb_vld_p1;
    logic [1:0]           cdb_kind_p1;
    logic [ROB_IDX_W-1:0] cdb_pos_p1;
    logic [WORD_W-1:0]    cdb_res_p1;
    logic                 cdb_jen_p1;
    logic [ADDR_W-1:0]    cdb_ja_p1;

    logic                 gnt_ex, gnt_ld, gnt_st, gnt_any;
    logic [1:0]           gnt_kind;
    logic [ROB_IDX_W-1:0] sel_pos;
    logic [WORD_W-1:0]    sel_res;
    logic                 sel_jen;
    logic [ADDR_W-1:0]    sel_ja;
    logic                 acc_ex, acc_ld, acc_st;
    logic                 conflict;

    // First occupied slot scanning circularly from rr_ptr. rr_ptr never
    // holds 3, but that encoding falls back to the EX-first order.
    always_comb begin
        gnt_ex = 1'b0;
        gnt_ld = 1'b0;
        gnt_st = 1'b0;
        case (rr_ptr)
            2'd1: begin
                if (occ_ld_p0)      gnt_ld = 1'b1;
                else if (occ_st_p0) gnt_st = 1'b1;
                else if (occ_ex_p0) gnt_ex = 1'b1;
            end
            2'd2: begin
                if (occ_st_p0)      gnt_st = 1'b1;
                else if (occ_ex_p0) gnt_ex = 1'b1;
                else if (occ_ld_p0) gnt_ld = 1'b1;
            end
            default: begin
                if (occ_ex_p0)      gnt_ex = 1'b1;
                else if (occ_ld_p0) gnt_ld = 1'b1;
                else if (occ_st_p0) gnt_st = 1'b1;
            end
        endcase
    end

    assign gnt_any  = gnt_ex | gnt_ld | gnt_st;
    assign gnt_kind = gnt_ld ? KIND_LD : (gnt_st ? KIND_ST : KIND_EX);

    // LD never redirects; ST carries no result and never redirects.
    always_comb begin
        sel_pos = ex_pos_p0;
        sel_res = ex_res_p0;
        sel_jen = ex_jen_p0;
        sel_ja  = ex_ja_p0;
        if (gnt_ld) begin
            sel_pos = ld_pos_p0;
            sel_res = ld_res_p0;
            sel_jen = 1'b0;
            sel_ja  = '0;
        end else if (gnt_st) begin
            sel_pos = st_pos_p0;
            sel_res = '0;
            sel_jen = 1'b0;
            sel_ja  = '0;
        end
    end

    // A slot being drained this edge can take a new entry (refill), so ready
    // depends on the grant but never on the source's own valid.
    assign ex_ready_out = rdy_in & ~clear_branch_in & (~occ_ex_p0 | gnt_ex);
    assign ld_ready_out = rdy_in & ~clear_branch_in & (~occ_ld_p0 | gnt_ld);
    assign st_ready_out = rdy_in & ~clear_branch_in & (~occ_st_p0 | gnt_st);

    assign acc_ex = ex_valid_in & ex_ready_out;
    assign acc_ld = ld_valid_in & ld_ready_out;
    assign acc_st = st_valid_in & st_ready_out;

    assign conflict = (occ_ex_p0 & occ_ld_p0) | (occ_ex_p0 & occ_st_p0) |
                      (occ_ld_p0 & occ_st_p0);

    // Control: occupancy, round-robin pointer, counter and broadcast register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            occ_ex_p0    <= 1'b0;
            occ_ld_p0    <= 1'b0;
            occ_st_p0    <= 1'b0;
            rr_ptr       <= KIND_EX;
            conflict_cnt <= '0;
            cdb_vld_p1   <= 1'b0;
            cdb_kind_p1  <= '0;
            cdb_pos_p1   <= '0;
            cdb_res_p1   <= '0;
            cdb_jen_p1   <= 1'b0;
            cdb_ja_p1    <= '0;
        end else if (rdy_in) begin
            // Occupancy is sampled before this edge's update; flush does not
            // suppress the count.
            if (conflict)
                conflict_cnt <= sat_inc(conflict_cnt);
            if (clear_branch_in) begin
                occ_ex_p0  <= 1'b0;
                occ_ld_p0  <= 1'b0;
                occ_st_p0  <= 1'b0;
                rr_ptr     <= KIND_EX;
                cdb_vld_p1 <= 1'b0;
            end else begin
                occ_ex_p0 <= acc_ex | (occ_ex_p0 & ~gnt_ex);
                occ_ld_p0 <= acc_ld | (occ_ld_p0 & ~gnt_ld);
                occ_st_p0 <= acc_st | (occ_st_p0 & ~gnt_st);
                if (gnt_any) begin
                    cdb_vld_p1  <= 1'b1;
                    cdb_kind_p1 <= gnt_kind;
                    cdb_pos_p1  <= sel_pos;
                    cdb_res_p1  <= sel_res;
                    cdb_jen_p1  <= sel_jen;
                    cdb_ja_p1   <= sel_ja;
                    rr_ptr      <= next_ptr(gnt_kind);
                end else begin
                    cdb_vld_p1  <= 1'b0;
                end
            end
        end
    end

    // Slot payloads carry no reset; occupancy alone decides whether they matter.
    always_ff @(posedge clk_in) begin
        if (acc_ex) begin
            ex_pos_p0 <= ex_rob_pos_in;
            ex_res_p0 <= ex_res_in;
            ex_jen_p0 <= ex_jump_en_in;
            ex_ja_p0  <= ex_jump_a_in;
        end
        if (acc_ld) begin
            ld_pos_p0 <= ld_rob_pos_in;
            ld_res_p0 <= ld_res_in;
        end
        if (acc_st)
            st_pos_p0 <= st_rob_pos_in;
    end

    assign cdb_valid_out    = cdb_vld_p1;
    assign cdb_kind_out     = cdb_kind_p1;
    assign cdb_rob_pos_out  = cdb_pos_p1;
    assign cdb_res_out      = cdb_res_p1;
    assign cdb_jump_en_out  = cdb_jen_p1;
    assign cdb_jump_a_out   = cdb_ja_p1;
    assign conflict_cnt_out = conflict_cnt;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    localparam int WORD_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int ROB_IDX_W = 4;
    localparam int CNT_W     = 3;   // narrow so saturation is reachable

    logic                 clk, rst, rdy, clr;
    logic                 ex_valid, ex_ready, ex_jump_en;
    logic [ROB_IDX_W-1:0] ex_rob_pos;
    logic [WORD_W-1:0]    ex_res;
    logic [ADDR_W-1:0]    ex_jump_a;
    logic                 ld_valid, ld_ready;
    logic [ROB_IDX_W-1:0] ld_rob_pos;
    logic [WORD_W-1:0]    ld_res;
    logic                 st_valid, st_ready;
    logic [ROB_IDX_W-1:0] st_rob_pos;
    logic                 cdb_valid, cdb_jump_en;
    logic [1:0]           cdb_kind;
    logic [ROB_IDX_W-1:0] cdb_rob_pos;
    logic [WORD_W-1:0]    cdb_res;
    logic [ADDR_W-1:0]    cdb_jump_a;
    logic [CNT_W-1:0]     conflict_cnt;

    int checks = 0;
    int errors = 0;

    cdb_arbiter #(
        .WORD_W(WORD_W), .ADDR_W(ADDR_W), .ROB_IDX_W(ROB_IDX_W), .CNT_W(CNT_W)
    ) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear_branch_in(clr),
        .ex_valid_in(ex_valid), .ex_ready_out(ex_ready), .ex_rob_pos_in(ex_rob_pos),
        .ex_res_in(ex_res), .ex_jump_en_in(ex_jump_en), .ex_jump_a_in(ex_jump_a),
        .ld_valid_in(ld_valid), .ld_ready_out(ld_ready), .ld_rob_pos_in(ld_rob_pos),
        .ld_res_in(ld_res),
        .st_valid_in(st_valid), .st_ready_out(st_ready), .st_rob_pos_in(st_rob_pos),
        .cdb_valid_out(cdb_valid), .cdb_kind_out(cdb_kind), .cdb_rob_pos_out(cdb_rob_pos),
        .cdb_res_out(cdb_res), .cdb_jump_en_out(cdb_jump_en), .cdb_jump_a_out(cdb_jump_a),
        .conflict_cnt_out(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        exv;  logic [3:0] exp; logic [31:0] exr; logic exj; logic [31:0] exa;
        logic        ldv;  logic [3:0] ldp; logic [31:0] ldr;
        logic        stv;  logic [3:0] stp;
        logic [2:0]  erdy;                     // {ex, ld, st} ready before the edge
        logic        ev;   logic [1:0] ek;  logic [3:0] ep; logic [31:0] er;
        logic        ej;   logic [31:0] ea; logic [2:0] ec;
    } vec_t;

    function automatic vec_t mk(
        input logic exv, input logic [3:0] exp, input logic [31:0] exr,
        input logic exj, input logic [31:0] exa,
        input logic ldv, input logic [3:0] ldp, input logic [31:0] ldr,
        input logic stv, input logic [3:0] stp, input logic [2:0] erdy,
        input logic ev, input logic [1:0] ek, input logic [3:0] ep,
        input logic [31:0] er, input logic ej, input logic [31:0] ea,
        input logic [2:0] ec);
        vec_t v;
        v.exv = exv; v.exp = exp; v.exr = exr; v.exj = exj; v.exa = exa;
        v.ldv = ldv; v.ldp = ldp; v.ldr = ldr; v.stv = stv; v.stp = stp;
        v.erdy = erdy; v.ev = ev; v.ek = ek; v.ep = ep; v.er = er;
        v.ej = ej; v.ea = ea; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rdy(input string tag, input logic [2:0] exp);
        chk({tag, " ready"}, {61'd0, ex_ready, ld_ready, st_ready}, {61'd0, exp});
    endtask

    task automatic chk_cdb(input string tag, input logic v, input logic [1:0] k,
                           input logic [3:0] p, input logic [31:0] r,
                           input logic j, input logic [31:0] a, input logic [2:0] c);
        chk({tag, " valid"}, {63'd0, cdb_valid}, {63'd0, v});
        chk({tag, " kind"}, {62'd0, cdb_kind}, {62'd0, k});
        chk({tag, " pos"}, {60'd0, cdb_rob_pos}, {60'd0, p});
        chk({tag, " res"}, {32'd0, cdb_res}, {32'd0, r});
        chk({tag, " jump_en"}, {63'd0, cdb_jump_en}, {63'd0, j});
        chk({tag, " jump_a"}, {32'd0, cdb_jump_a}, {32'd0, a});
        chk({tag, " cnt"}, {61'd0, conflict_cnt}, {61'd0, c});
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_rob_pos = 0; ex_res = 0; ex_jump_en = 0; ex_jump_a = 0;
        ld_valid = 0; ld_rob_pos = 0; ld_res = 0;
        st_valid = 0; st_rob_pos = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[12];

    initial begin
        // Test 2 (all three at once) first so rr_ptr starts at 0, then a
        // single EX request, then a back-to-back LD stream.
        vecs[0]  = mk(1,1,'h22,1,'h40, 1,2,'hAB, 1,5, 3'b111, 0,0,0,0,0,0, 0);
        vecs[1]  = mk(0,0,0,0,0, 0,0,0, 0,0, 3'b100, 1,0,1,'h22,1,'h40, 1);
        vecs[2]  = mk(0,0,0,0,0, 0,0,0, 0,0, 3'b110, 1,1,2,'hAB,0,0, 2);
        vecs[3]  = mk(0,0,0,0,0, 0,0,0, 0,0, 3'b111, 1,2,5,0,0,0, 2);
        vecs[4]  = mk(1,3,'h11,1,'h100, 0,0,0, 0,0, 3'b111, 0,2,5,0,0,0, 2);
        vecs[5]  = mk(0,0,0,0,0, 0,0,0, 0,0, 3'b111, 1,0,3,'h11,1,'h100, 2);
        vecs[6]  = mk(0,0,0,0,0, 1,1,'h1001, 0,0, 3'b111, 0,0,3,'h11,1,'h100, 2);
        vecs[7]  = mk(0,0,0,0,0, 1,2,'h1002, 0,0, 3'b111, 1,1,1,'h1001,0,0, 2);
        vecs[8]  = mk(0,0,0,0,0, 1,3,'h1003, 0,0, 3'b111, 1,1,2,'h1002,0,0, 2);
        vecs[9]  = mk(0,0,0,0,0, 1,4,'h1004, 0,0, 3'b111, 1,1,3,'h1003,0,0, 2);
        vecs[10] = mk(0,0,0,0,0, 0,0,0, 0,0, 3'b111, 1,1,4,'h1004,0,0, 2);
        vecs[11] = mk(0,0,0,0,0, 0,0,0, 0,0, 3'b111, 0,1,4,'h1004,0,0, 2);

        rst = 1; rdy = 1; clr = 0;
        idle_inputs();
        step();
        step();
        rst = 0;
        #1;
        chk_cdb("reset", 0, 0, 0, 0, 0, 0, 0);
        chk_rdy("reset", 3'b111);

        for (int i = 0; i < 12; i++) begin
            ex_valid = vecs[i].exv; ex_rob_pos = vecs[i].exp; ex_res = vecs[i].exr;
            ex_jump_en = vecs[i].exj; ex_jump_a = vecs[i].exa;
            ld_valid = vecs[i].ldv; ld_rob_pos = vecs[i].ldp; ld_res = vecs[i].ldr;
            st_valid = vecs[i].stv; st_rob_pos = vecs[i].stp;
            #1;
            chk_rdy($sformatf("vec%0d", i), vecs[i].erdy);
            step();
            chk_cdb($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ek, vecs[i].ep,
                    vecs[i].er, vecs[i].ej, vecs[i].ea, vecs[i].ec);
        end

        // Flush with EX and LD occupied; neither may ever broadcast.
        idle_inputs();
        ex_valid = 1; ex_rob_pos = 6; ex_res = 'h66; ex_jump_en = 1; ex_jump_a = 'h200;
        ld_valid = 1; ld_rob_pos = 7; ld_res = 'h77;
        step();
        chk_cdb("flush_fill", 0, 1, 4, 'h1004, 0, 0, 2);
        clr = 1;                       // EX keeps requesting; must not be taken
        #1;
        chk_rdy("flush_pulse", 3'b000);
        step();
        chk_cdb("flush_edge", 0, 1, 4, 'h1004, 0, 0, 3);
        clr = 0;
        idle_inputs();
        #1;
        chk_rdy("flush_after", 3'b111);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_cdb($sformatf("flush_post%0d", i), 0, 1, 4, 'h1004, 0, 0, 3);
        end

        // Freeze with two slots occupied and a live broadcast.
        ex_valid = 1; ex_rob_pos = 1; ex_res = 'h31;
        ld_valid = 1; ld_rob_pos = 2; ld_res = 'h32;
        st_valid = 1; st_rob_pos = 3;
        step();
        idle_inputs();
        chk_cdb("frz_fill", 0, 1, 4, 'h1004, 0, 0, 3);
        step();
        chk_cdb("frz_ex", 1, 0, 1, 'h31, 0, 0, 4);
        rdy = 0;
        ex_valid = 1; ex_rob_pos = 9; ex_res = 'h99;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_rdy($sformatf("frz%0d", i), 3'b000);
            step();
            chk_cdb($sformatf("frz%0d", i), 1, 0, 1, 'h31, 0, 0, 4);
        end
        rdy = 1;
        idle_inputs();
        #1;
        chk_rdy("frz_resume", 3'b110);
        step();
        chk_cdb("frz_ld", 1, 1, 2, 'h32, 0, 0, 5);
        step();
        chk_cdb("frz_st", 1, 2, 3, 0, 0, 0, 5);
        step();
        chk_cdb("frz_done", 0, 2, 3, 0, 0, 0, 5);

        // Reset mid-operation with all three slots occupied and rr_ptr at LD.
        ex_valid = 1; ex_rob_pos = 8; ex_res = 'h81;
        ld_valid = 1; ld_rob_pos = 9; ld_res = 'h91;
        st_valid = 1; st_rob_pos = 10;
        step();
        idle_inputs();
        ex_valid = 1; ex_rob_pos = 12; ex_res = 'hC1;   // refill while EX drains
        #1;
        chk_rdy("rst_refill", 3'b100);
        step();
        chk_cdb("rst_pre", 1, 0, 8, 'h81, 0, 0, 6);
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
        chk_cdb("rst_mid", 0, 0, 0, 0, 0, 0, 0);
        st_valid = 1; st_rob_pos = 11;
        #1;
        chk_rdy("rst_after", 3'b111);
        step();
        idle_inputs();
        chk_cdb("rst_st_acc", 0, 0, 0, 0, 0, 0, 0);
        step();
        chk_cdb("rst_st_bc", 1, 2, 11, 0, 0, 0, 0);
        step();
        chk_cdb("rst_no_ghost", 0, 2, 11, 0, 0, 0, 0);

        // All sources requesting every cycle: rotation EX, LD, ST and the
        // counter saturating at 7.
        ex_valid = 1; ex_rob_pos = 1; ex_res = 'h5;
        ld_valid = 1; ld_rob_pos = 2; ld_res = 'h6;
        st_valid = 1; st_rob_pos = 3;
        step();
        for (int i = 0; i < 11; i++) begin
            step();
            chk($sformatf("sat_kind%0d", i), {62'd0, cdb_kind}, 64'(i % 3));
            chk($sformatf("sat_valid%0d", i), {63'd0, cdb_valid}, 64'd1);
        end
        chk("sat_cnt", {61'd0, conflict_cnt}, 64'd7);
        step();
        chk("sat_hold", {61'd0, conflict_cnt}, 64'd7);
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
